wb_trace_buffer: RTL

- Downstream observer of the pipelined RISC-V core; consumes the core's writeback and data-memory observation outputs.
- Observed outputs: reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data.
- Each cycle with a retired event is packed into one record and pushed into an internal FIFO.
- The FIFO is drained by a valid/ready consumer (debug port / testbench monitor).
- Drops on overflow are counted, never stall the core.

---
 rtl/wb_trace_buffer_if.sv | 67 ++++++
 rtl/wb_trace_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer_if
//
// Bundles the observation inputs, the control strobes and the valid/ready
// drain port of wb_trace_buffer.
//
// Parameters: DATA_W (reg/memory data width), ADDR_W (memory address width),
//             DEPTH (FIFO entries, power of two >= 2).
//
// Signals (direction seen from the trace buffer, i.e. the slave modport):
//   trace_en       in   capture enable
//   reg_write_sig  in   core register write strobe
//   reg_num        in   destination register (5 bits)
//   reg_data       in   value written to the register file
//   wr / rd        in   data memory write / read strobes
//   addr           in   data memory address
//   wr_data        in   store data
//   rd_data        in   load data
//   clr_ovf        in   clears overflow and drop_cnt
//   out_ready      in   consumer accepts the head record
//   out_valid      out  head record available
//   out_data       out  head record (REC_W bits)
//   level          out  occupancy, 0..DEPTH
//   overflow       out  sticky "a record was dropped"
//   drop_cnt       out  saturating dropped-record count (16 bits)
//
// Modports: master = core/consumer side, slave = trace buffer.
// ---------------------------------------------------------------------------
interface wb_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16
);
  localparam int REC_W = 3 + 5 + DATA_W + ADDR_W + DATA_W + 32;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              trace_en;
  logic              reg_write_sig;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              clr_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [REC_W-1:0]  out_data;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [15:0]       drop_cnt;

  modport master (
    output trace_en, reg_write_sig, reg_num, reg_data,
    output wr, rd, addr, wr_data, rd_data,
    output clr_ovf, out_ready,
    input  out_valid, out_data, level, overflow, drop_cnt
  );

  modport slave (
    input  trace_en, reg_write_sig, reg_num, reg_data,
    input  wr, rd, addr, wr_data, rd_data,
    input  clr_ovf, out_ready,
    output out_valid, out_data, level, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
//
// Passive observer of the pipelined RISC-V core's writeback and data-memory
// activity. Every cycle carrying a traced event is packed into one record
// and written into a DEPTH-entry FIFO that a valid/ready consumer drains.
// The core is never stalled: when the FIFO is full and nothing is popped,
// the new record is dropped, the sticky overflow flag is set and drop_cnt
// counts the loss (saturating at 0xFFFF).
//
// Record layout, MSB -> LSB:
//   {f_reg, f_wr, f_rd, reg_num[4:0], reg_data, addr, mem_data, ts[31:0]}
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (flushes the FIFO, clears flags)
//   bus    wb_trace_buffer_if.slave: observation inputs, trace_en, clr_ovf
//          and the out_valid/out_ready/out_data drain port plus the
//          level/overflow/drop_cnt status outputs
//
// Build option:
//   WB_TRACE_TIMESTAMP_EN  when defined, a free-running 32-bit cycle counter
//                          (0 in the first cycle after reset) fills the ts
//                          field; otherwise ts is constant 0 and no counter
//                          exists. Port widths are identical in both builds.
// ---------------------------------------------------------------------------
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  wb_trace_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = 3 + 5 + DATA_W + ADDR_W + DATA_W + 32;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Saturating increment for the 16-bit drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Memory data field: a store wins over a load when both strobes are set.
  function automatic logic [DATA_W-1:0] sel_mem_data(
    input logic              wr_i,
    input logic              rd_i,
    input logic [DATA_W-1:0] wr_data_i,
    input logic [DATA_W-1:0] rd_data_i
  );
    if (wr_i)      return wr_data_i;
    else if (rd_i) return rd_data_i;
    else           return '0;
  endfunction

  // ---- timestamp source --------------------------------------------------
  logic [31:0] ts_p0;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end

  assign ts_p0 = ts_cnt;
`else
  assign ts_p0 = '0;
`endif

  // ---- stage p0: record assembly from the current cycle's observation ----
  logic              f_reg_p0;
  logic              f_wr_p0;
  logic              f_rd_p0;
  logic              vld_p0;
  logic [4:0]        reg_num_p0;
  logic [DATA_W-1:0] reg_data_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] mem_data_p0;
  logic [REC_W-1:0]  rec_p0;

  always_comb begin
    // Writes to x0 are architecturally invisible and are not traced.
    f_reg_p0    = bus.reg_write_sig & (bus.reg_num != 5'd0);
    f_wr_p0     = bus.wr;
    f_rd_p0     = bus.rd;
    vld_p0      = bus.trace_en & (f_reg_p0 | f_wr_p0 | f_rd_p0);
    // Unused fields are zeroed so records compare cleanly downstream.
    reg_num_p0  = f_reg_p0 ? bus.reg_num : 5'd0;
    reg_data_p0 = f_reg_p0 ? bus.reg_data : '0;
    addr_p0     = (f_wr_p0 | f_rd_p0) ? bus.addr : '0;
    mem_data_p0 = sel_mem_data(bus.wr, bus.rd, bus.wr_data, bus.rd_data);
    rec_p0      = {f_reg_p0, f_wr_p0, f_rd_p0, reg_num_p0, reg_data_p0,
                   addr_p0, mem_data_p0, ts_p0};
  end

  // ---- stage p1: FIFO storage and occupancy ------------------------------
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [LVL_W-1:0] count_nxt;

  assign empty = (count == '0);
  assign full  = (count == FULL_LVL);
  // An empty FIFO cannot pop, so a same-cycle push simply lands.
  assign pop   = ~empty & bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = vld_p0 & (~full | pop);
  assign drop  = vld_p0 & full & ~pop;

  assign count_nxt = count + LVL_W'(push) - LVL_W'(pop);

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // ---- overflow bookkeeping ----------------------------------------------
  logic        overflow_q;
  logic [15:0] drop_cnt_q;

  // A drop in the same cycle as clr_ovf takes priority and restarts the
  // count at one, so the loss is never hidden by the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      drop_cnt_q <= bus.clr_ovf ? 16'd1 : sat_inc16(drop_cnt_q);
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  // ---- outputs -----------------------------------------------------------
  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.level     = count;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
